// File: rtl/craps_round_ctrl_if.sv
// Roll/control and status bundle between the dice-sum generator, the craps
// round controller and the display/score logic.
interface craps_round_ctrl_if #(
  parameter int SUM_W = 4,
  parameter int CNT_W = 8
);
  logic             clock_en;
  logic             roll_valid;
  logic [SUM_W-1:0] num;
  logic             new_game;

  logic             D7;
  logic             D711;
  logic             D2312;
  logic             illegal;
  logic [SUM_W-1:0] point;
  logic             point_set;
  logic             win;
  logic             lose;
  logic [CNT_W-1:0] win_count;
  logic [CNT_W-1:0] loss_count;
  logic [CNT_W-1:0] roll_count;

  modport master (
    output clock_en, roll_valid, num, new_game,
    input  D7, D711, D2312, illegal, point, point_set, win, lose,
           win_count, loss_count, roll_count
  );

  modport slave (
    input  clock_en, roll_valid, num, new_game,
    output D7, D711, D2312, illegal, point, point_set, win, lose,
           win_count, loss_count, roll_count
  );
endinterface

// File: rtl/craps_round_ctrl.sv
// Craps round controller: classifies each accepted dice sum, runs the
// come-out / point / win / lose round and keeps saturating statistics.
module craps_round_ctrl #(
  parameter int SUM_W   = 4,
  parameter int MAX_SUM = 12,
  parameter int CNT_W   = 8
) (
  input logic               clock,
  input logic               reset_n,
  craps_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    COME_OUT = 2'd0,
    POINT    = 2'd1,
    WIN      = 2'd2,
    LOSE     = 2'd3
  } state_e;

  localparam logic [SUM_W-1:0] SUM_2   = SUM_W'(2);
  localparam logic [SUM_W-1:0] SUM_3   = SUM_W'(3);
  localparam logic [SUM_W-1:0] SUM_7   = SUM_W'(7);
  localparam logic [SUM_W-1:0] SUM_11  = SUM_W'(11);
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(MAX_SUM);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] point_q;
  logic             d7_q, d711_q, d2312_q, illegal_q;
  logic [CNT_W-1:0] win_cnt_q, loss_cnt_q, roll_cnt_q;

  logic sample, legal, in_play, accept;
  logic is_7, is_natural, is_craps, hit_point;
  logic enter_win, enter_lose;
  logic win, lose, point_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign sample     = bus.clock_en & bus.roll_valid & ~bus.new_game;
  assign legal      = (bus.num >= SUM_2) && (bus.num <= SUM_MAX);
  assign in_play    = (state_q == COME_OUT) || (state_q == POINT);
  assign accept     = sample & legal & in_play;

  assign is_7       = (bus.num == SUM_7);
  assign is_natural = is_7 || (bus.num == SUM_11);
  assign is_craps   = (bus.num == SUM_2) || (bus.num == SUM_3) || (bus.num == SUM_MAX);
  assign hit_point  = (bus.num == point_q);

  // Only accepted rolls move the FSM, and they never start in WIN/LOSE,
  // so reaching WIN/LOSE through accept is always a fresh entry.
  assign enter_win  = accept && (state_d == WIN);
  assign enter_lose = accept && (state_d == LOSE);

  // NOTE: asynchronous active-low reset; sequential state uses non-blocking
  // assignments so every register samples the pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COME_OUT;
    end else if (bus.clock_en) begin
      state_q <= state_d;
    end
  end

  // NOTE: defaulting state_d first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    if (bus.new_game) begin
      state_d = COME_OUT;
    end else if (accept) begin
      case (state_q)
        COME_OUT: begin
          if (is_natural)    state_d = WIN;
          else if (is_craps) state_d = LOSE;
          else               state_d = POINT;
        end
        POINT: begin
          if (hit_point) state_d = WIN;
          else if (is_7) state_d = LOSE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    win       = 1'b0;
    lose      = 1'b0;
    point_set = 1'b0;
    case (state_q)
      POINT:   point_set = 1'b1;
      WIN:     win       = 1'b1;
      LOSE:    lose      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      point_q    <= '0;
      d7_q       <= 1'b0;
      d711_q     <= 1'b0;
      d2312_q    <= 1'b0;
      illegal_q  <= 1'b0;
      win_cnt_q  <= '0;
      loss_cnt_q <= '0;
      roll_cnt_q <= '0;
    end else if (bus.clock_en) begin
      // Out-of-range rolls are flagged only while a round is in play.
      illegal_q <= sample & in_play & ~legal;
      if (bus.new_game) begin
        point_q <= '0;
        d7_q    <= 1'b0;
        d711_q  <= 1'b0;
        d2312_q <= 1'b0;
      end else if (accept) begin
        d7_q       <= is_7;
        d711_q     <= is_natural;
        d2312_q    <= is_craps;
        roll_cnt_q <= sat_inc(roll_cnt_q);
        if ((state_q == COME_OUT) && (state_d == POINT)) point_q <= bus.num;
      end
      if (enter_win)  win_cnt_q  <= sat_inc(win_cnt_q);
      if (enter_lose) loss_cnt_q <= sat_inc(loss_cnt_q);
    end
  end

  assign bus.D7         = d7_q;
  assign bus.D711       = d711_q;
  assign bus.D2312      = d2312_q;
  assign bus.illegal    = illegal_q;
  assign bus.point      = point_q;
  assign bus.point_set  = point_set;
  assign bus.win        = win;
  assign bus.lose       = lose;
  assign bus.win_count  = win_cnt_q;
  assign bus.loss_count = loss_cnt_q;
  assign bus.roll_count = roll_cnt_q;

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Self-checking bench for craps_round_ctrl: directed vector table, hand-written
// reset/saturation sequences and randomized rolls against a round-level model.
module tb_craps_round_ctrl;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  craps_round_ctrl_if #(.SUM_W(4), .CNT_W(8)) bus  ();
  craps_round_ctrl_if #(.SUM_W(4), .CNT_W(2)) bus2 ();

  craps_round_ctrl #(.SUM_W(4), .MAX_SUM(12), .CNT_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  craps_round_ctrl #(.SUM_W(4), .MAX_SUM(12), .CNT_W(2)) dut_sat (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en, ng, rv;
    logic [3:0] num;
    logic       win, lose, pset;
    logic [3:0] point;
    logic       d7, d711, d2312, ill;
    int         rolls, wins, losses;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic en, ng, rv, input int num,
                             input logic win, lose, pset, input int point,
                             input logic d7, d711, d2312, ill,
                             input int rolls, wins, losses);
    vec_t t;
    t.en = en; t.ng = ng; t.rv = rv; t.num = 4'(num);
    t.win = win; t.lose = lose; t.pset = pset; t.point = 4'(point);
    t.d7 = d7; t.d711 = d711; t.d2312 = d2312; t.ill = ill;
    t.rolls = rolls; t.wins = wins; t.losses = losses;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_dut();
    return {29'd0, bus.win, bus.lose, bus.point_set, bus.point,
            bus.D7, bus.D711, bus.D2312, bus.illegal,
            bus.roll_count, bus.win_count, bus.loss_count};
  endfunction

  function automatic logic [63:0] pack_vec(input vec_t t);
    return {29'd0, t.win, t.lose, t.pset, t.point, t.d7, t.d711, t.d2312, t.ill,
            8'(t.rolls), 8'(t.wins), 8'(t.losses)};
  endfunction

  task automatic drive(input logic en, ng, rv, input int num);
    bus.clock_en   = en;
    bus.new_game   = ng;
    bus.roll_valid = rv;
    bus.num        = 4'(num);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Round-level reference model: a round is "in play" until won or lost;
  // an established point is simply a non-zero number.
  int m_point, m_rolls, m_wins, m_losses;
  bit m_won, m_lost, m_d7, m_d711, m_d2312, m_ill;

  task automatic model_reset();
    m_point = 0; m_rolls = 0; m_wins = 0; m_losses = 0;
    m_won = 0; m_lost = 0; m_d7 = 0; m_d711 = 0; m_d2312 = 0; m_ill = 0;
  endtask

  task automatic model_step(input bit en, ng, rv, input int num);
    if (!en) return;
    m_ill = 0;
    if (ng) begin
      m_won = 0; m_lost = 0; m_point = 0; m_d7 = 0; m_d711 = 0; m_d2312 = 0;
    end else if (rv && !m_won && !m_lost) begin
      if (num < 2 || num > 12) begin
        m_ill = 1;
      end else begin
        m_rolls = (m_rolls < 255) ? m_rolls + 1 : 255;
        m_d7    = (num == 7);
        m_d711  = (num == 7 || num == 11);
        m_d2312 = (num == 2 || num == 3 || num == 12);
        if (m_point == 0) begin
          if (num == 7 || num == 11)                m_won  = 1;
          else if (num == 2 || num == 3 || num == 12) m_lost = 1;
          else                                       m_point = num;
        end else if (num == m_point) begin
          m_won = 1;
        end else if (num == 7) begin
          m_lost = 1;
        end
        if (m_won)  m_wins   = (m_wins   < 255) ? m_wins   + 1 : 255;
        if (m_lost) m_losses = (m_losses < 255) ? m_losses + 1 : 255;
      end
    end
  endtask

  function automatic logic [63:0] pack_model();
    bit pset;
    pset = (m_point != 0) && !m_won && !m_lost;
    return {29'd0, m_won, m_lost, pset, 4'(m_point), m_d7, m_d711, m_d2312, m_ill,
            8'(m_rolls), 8'(m_wins), 8'(m_losses)};
  endfunction

  initial begin
    drive(0, 0, 0, 0);
    bus2.clock_en = 0; bus2.new_game = 0; bus2.roll_valid = 0; bus2.num = '0;

    // Come-out sweep 2..12, each on a fresh round.
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  0,0,0));
    tbl.push_back(v(1,0,1,2,  0,1,0,0,  0,0,1,0,  1,0,1));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  1,0,1));
    tbl.push_back(v(1,0,1,3,  0,1,0,0,  0,0,1,0,  2,0,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  2,0,2));
    tbl.push_back(v(1,0,1,4,  0,0,1,4,  0,0,0,0,  3,0,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  3,0,2));
    tbl.push_back(v(1,0,1,5,  0,0,1,5,  0,0,0,0,  4,0,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  4,0,2));
    tbl.push_back(v(1,0,1,6,  0,0,1,6,  0,0,0,0,  5,0,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  5,0,2));
    tbl.push_back(v(1,0,1,7,  1,0,0,0,  1,1,0,0,  6,1,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  6,1,2));
    tbl.push_back(v(1,0,1,8,  0,0,1,8,  0,0,0,0,  7,1,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  7,1,2));
    tbl.push_back(v(1,0,1,9,  0,0,1,9,  0,0,0,0,  8,1,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  8,1,2));
    tbl.push_back(v(1,0,1,10, 0,0,1,10, 0,0,0,0,  9,1,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0,  9,1,2));
    tbl.push_back(v(1,0,1,11, 1,0,0,0,  0,1,0,0, 10,2,2));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0, 10,2,2));
    tbl.push_back(v(1,0,1,12, 0,1,0,0,  0,0,1,0, 11,2,3));
    // Point round 5,8,6,5 then 4,7.
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0, 11,2,3));
    tbl.push_back(v(1,0,1,5,  0,0,1,5,  0,0,0,0, 12,2,3));
    tbl.push_back(v(1,0,1,8,  0,0,1,5,  0,0,0,0, 13,2,3));
    tbl.push_back(v(1,0,1,6,  0,0,1,5,  0,0,0,0, 14,2,3));
    tbl.push_back(v(1,0,1,5,  1,0,0,5,  0,0,0,0, 15,3,3));
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0, 15,3,3));
    tbl.push_back(v(1,0,1,4,  0,0,1,4,  0,0,0,0, 16,3,3));
    tbl.push_back(v(1,0,1,7,  0,1,0,4,  1,1,0,0, 17,3,4));
    // Illegal rolls in COME_OUT, ignored rolls in WIN.
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0, 17,3,4));
    tbl.push_back(v(1,0,1,0,  0,0,0,0,  0,0,0,1, 17,3,4));
    tbl.push_back(v(1,0,1,13, 0,0,0,0,  0,0,0,1, 17,3,4));
    tbl.push_back(v(1,0,0,0,  0,0,0,0,  0,0,0,0, 17,3,4));
    tbl.push_back(v(1,0,1,7,  1,0,0,0,  1,1,0,0, 18,4,4));
    tbl.push_back(v(1,0,1,7,  1,0,0,0,  1,1,0,0, 18,4,4));
    tbl.push_back(v(1,0,1,0,  1,0,0,0,  1,1,0,0, 18,4,4));
    // new_game priority and clock_en hold, including a held illegal pulse.
    tbl.push_back(v(1,1,0,0,  0,0,0,0,  0,0,0,0, 18,4,4));
    tbl.push_back(v(1,0,1,6,  0,0,1,6,  0,0,0,0, 19,4,4));
    tbl.push_back(v(1,1,1,7,  0,0,0,0,  0,0,0,0, 19,4,4));
    tbl.push_back(v(0,0,1,6,  0,0,0,0,  0,0,0,0, 19,4,4));
    tbl.push_back(v(1,0,1,8,  0,0,1,8,  0,0,0,0, 20,4,4));
    tbl.push_back(v(0,0,1,8,  0,0,1,8,  0,0,0,0, 20,4,4));
    tbl.push_back(v(0,1,0,0,  0,0,1,8,  0,0,0,0, 20,4,4));
    tbl.push_back(v(1,0,1,0,  0,0,1,8,  0,0,0,1, 20,4,4));
    tbl.push_back(v(0,0,1,0,  0,0,1,8,  0,0,0,1, 20,4,4));
    tbl.push_back(v(1,0,0,0,  0,0,1,8,  0,0,0,0, 20,4,4));
    tbl.push_back(v(1,0,1,8,  1,0,0,8,  0,0,0,0, 21,5,4));

    // Reset state.
    repeat (2) step();
    check("reset_state", pack_dut(), 64'd0);
    check("reset_state_sat", {58'd0, bus2.win_count, bus2.roll_count, bus2.loss_count}, 64'd0);
    reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].ng, tbl[i].rv, int'(tbl[i].num));
      step();
      check($sformatf("vec%0d", i), pack_dut(), pack_vec(tbl[i]));
    end

    // Asynchronous reset mid-round with point 6 established.
    drive(1, 1, 0, 0); step();
    drive(1, 0, 1, 6); step();
    check("pre_reset_point", {60'd0, bus.point}, 64'd6);
    drive(1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 check("async_reset", pack_dut(), 64'd0);
    step();
    reset_n = 1'b1;
    drive(1, 0, 1, 7); step();
    check("first_edge_after_reset", pack_dut(),
          pack_vec(v(1,0,1,7, 1,0,0,0, 1,1,0,0, 1,1,0)));

    // Saturation with CNT_W=2: five won rounds.
    for (int k = 1; k <= 5; k++) begin
      bus2.clock_en = 1; bus2.new_game = 1; bus2.roll_valid = 0; bus2.num = 4'd0;
      step();
      bus2.new_game = 0; bus2.roll_valid = 1; bus2.num = 4'd7;
      step();
      check($sformatf("sat_round%0d", k),
            {58'd0, bus2.win_count, bus2.roll_count, bus2.loss_count, 1'b0, bus2.win},
            {58'd0, 2'((k < 3) ? k : 3), 2'((k < 3) ? k : 3), 2'd0, 1'b0, 1'b1});
    end
    bus2.clock_en = 0; bus2.roll_valid = 0;

    // Randomized rolls against the round-level model.
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit en, ng, rv;
      int num;
      en  = ($urandom_range(0, 99) < 85);
      ng  = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 99) < 70);
      num = $urandom_range(0, 15);
      drive(en, ng, rv, num);
      step();
      model_step(en, ng, rv, num);
      check($sformatf("rand%0d", c), pack_dut(), pack_model());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
